// File: rtl/dsp_bist_freezer.sv
// dsp_bist_freezer: I/O pipeline freezer around a DSP core with LFSR-driven, MISR-compacted self-test
module dsp_bist_freezer #(
    parameter int IN_W = 198,
    parameter int OUT_W = 205,
    parameter int IN_STAGES = 1,
    parameter int OUT_STAGES = 1,
    parameter int CORE_LAT = 2,
    parameter int CNT_W = 16,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  pin_in,
    output logic [IN_W-1:0]  core_in,
    input  logic [OUT_W-1:0] core_out,
    output logic [OUT_W-1:0] pin_out,
    input  logic             mode_bist,
    input  logic             start,
    input  logic [CNT_W-1:0] run_len,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature
);
    localparam int L = IN_STAGES + CORE_LAT + OUT_STAGES;
    localparam int SLICES = (OUT_W + 31) / 32;
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;
    logic [IN_W-1:0] in_pipe [IN_STAGES];
    logic [OUT_W-1:0] out_pipe [OUT_STAGES];
    logic [31:0] lfsr, misr, fold;
    logic [CNT_W-1:0] cnt;
    logic [L-1:0] vl, vl_next;
    logic [IN_W-1:0] vec, stage1;
    logic [SLICES*32-1:0] padded;
    logic accept;
    for (genvar i = 0; i < IN_W; i++) begin : g_vec
        assign vec[i] = lfsr[i % 32];
    end
    assign stage1 = state == RUN ? vec : state == DRAIN ? '0 : pin_in;
    assign vl_next = {vl[L-2:0], state == RUN};
    assign accept = start && mode_bist && (state == IDLE || state == DONE);
    assign core_in = in_pipe[IN_STAGES-1];
    assign pin_out = busy ? '0 : out_pipe[OUT_STAGES-1];
    assign signature = misr;
    always_comb begin
        padded = '0;
        padded[OUT_W-1:0] = out_pipe[OUT_STAGES-1];
        fold = '0;
        for (int s = 0; s < SLICES; s++) fold ^= padded[s*32 +: 32];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < IN_STAGES; s++) in_pipe[s] <= '0;
            for (int s = 0; s < OUT_STAGES; s++) out_pipe[s] <= '0;
        end else begin
            in_pipe[0] <= stage1;
            for (int s = 1; s < IN_STAGES; s++) in_pipe[s] <= in_pipe[s-1];
            out_pipe[0] <= core_out;
            for (int s = 1; s < OUT_STAGES; s++) out_pipe[s] <= out_pipe[s-1];
        end
    end
    // DRAIN exits one cycle early (on vl_next) so done lands exactly after the last compaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            misr <= '0;
            lfsr <= SEED;
            cnt <= '0;
            vl <= '0;
        end else begin
            vl <= vl_next;
            if (vl[L-1]) misr <= {misr[30:0], 1'b0} ^ (misr[31] ? POLY : 32'd0) ^ fold;
            case (state)
                IDLE, DONE: if (accept) begin
                    cnt <= run_len;
                    misr <= '0;
                    if (run_len != '0) begin
                        state <= RUN;
                        busy <= 1'b1;
                        done <= 1'b0;
                    end else begin
                        state <= DONE;
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'd0);
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DRAIN;
                end
                DRAIN: if (vl_next == '0) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            endcase
        end
    end
endmodule
